// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive controller.
// State encoding, sample-point offset, minimum oversampling ratio and the
// effective-prescale function used when a frame starts.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  localparam int SAMPLE_OFS   = 2;
  localparam int MIN_PRESCALE = 8;

  // Effective oversampling ratio: LSB dropped, anything below the minimum clamped up.
  function automatic logic [15:0] eff_prescale(input logic [15:0] raw);
    logic [15:0] even;
    even = {raw[15:1], 1'b0};
    if (even < 16'(MIN_PRESCALE)) begin
      eff_prescale = 16'(MIN_PRESCALE);
    end else begin
      eff_prescale = even;
    end
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_counter.sv
// rx_edge_bit_counter: oversample (edge) and bit counters for the RX controller.
// edge_cnt runs 0..P-1 while enabled; bit_done marks edge_cnt==P-1.
// at_sample is raised one cycle ahead of edge_cnt==P/2+SAMPLE_OFS so that a strobe
// registered on it is high exactly while edge_cnt sits on the sample point.
module rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cnt_en,
  input  logic                  edge_clr,
  input  logic                  edge_set1,
  input  logic                  bit_clr,
  input  logic                  bit_inc,
  input  logic [PRESCALE_W-1:0] p_eff,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  bit_done,
  output logic                  at_sample
);

  logic [PRESCALE_W-1:0] edge_cnt_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [PRESCALE_W-1:0] p_last_s;
  logic [PRESCALE_W-1:0] samp_pre_s;

  assign p_last_s   = p_eff - PRESCALE_W'(1);
  assign samp_pre_s = (p_eff >> 1) + PRESCALE_W'(SAMPLE_OFS - 1);
  assign bit_done   = cnt_en && (edge_cnt_r == p_last_s);
  assign at_sample  = cnt_en && (edge_cnt_r == samp_pre_s);
  assign edge_cnt   = edge_cnt_r;
  assign bit_cnt    = bit_cnt_r;

  // Oversample index: clear/preload on frame boundaries, wrap at P-1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_r <= '0;
    end else if (edge_clr) begin
      edge_cnt_r <= '0;
    end else if (edge_set1) begin
      edge_cnt_r <= PRESCALE_W'(1);
    end else if (cnt_en) begin
      if (bit_done) begin
        edge_cnt_r <= '0;
      end else begin
        edge_cnt_r <= edge_cnt_r + PRESCALE_W'(1);
      end
    end else begin
      edge_cnt_r <= edge_cnt_r;
    end
  end

  // Data bit index within the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt_r <= '0;
    end else if (bit_clr) begin
      bit_cnt_r <= '0;
    end else if (bit_inc) begin
      bit_cnt_r <= bit_cnt_r + BIT_W'(1);
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame FSM driving sampler/checker/deserializer enables.
// Optional macro UART_RX_ERR_CNT_EN adds a saturating 8-bit frame error counter.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  dat_samp_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  deser_en,
  output logic                  data_valid,
`ifdef UART_RX_ERR_CNT_EN
  output logic [7:0]            frame_err_cnt,
`endif
  output logic                  busy
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  rx_state_e             state_r;
  logic [PRESCALE_W-1:0] p_r;
  logic [PRESCALE_W-1:0] p_nxt_s;
  logic                  par_en_r;
  logic                  par_bad_r;
  logic                  strt_chk_r;
  logic                  deser_r;
  logic                  par_chk_r;
  logic                  stp_chk_r;
  logic                  data_valid_r;
  logic                  busy_r;
  logic                  cnt_en_s;
  logic                  edge_clr_s;
  logic                  edge_set1_s;
  logic                  bit_clr_s;
  logic                  bit_inc_s;
  logic                  bit_done_s;
  logic                  at_sample_s;
  logic [BIT_W-1:0]      bit_cnt_s;
  logic                  last_bit_s;

  assign p_nxt_s    = PRESCALE_W'(eff_prescale(16'(PRESCALE)));
  assign last_bit_s = (bit_cnt_s == BIT_W'(DATA_WIDTH - 1));
  assign cnt_en_s   = (state_r != ST_IDLE);

  rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_W      (BIT_W)
  ) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .cnt_en    (cnt_en_s),
    .edge_clr  (edge_clr_s),
    .edge_set1 (edge_set1_s),
    .bit_clr   (bit_clr_s),
    .bit_inc   (bit_inc_s),
    .p_eff     (p_r),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt_s),
    .bit_done  (bit_done_s),
    .at_sample (at_sample_s)
  );

  // Counter controls: hold at 0 in IDLE, preload 1 on a back-to-back start from DONE.
  always_comb begin
    edge_clr_s  = 1'b0;
    edge_set1_s = 1'b0;
    bit_clr_s   = 1'b0;
    bit_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: edge_clr_s = 1'b1;
      ST_START: begin
        if (bit_done_s && !strt_glitch) begin
          bit_clr_s = 1'b1;
        end else begin
          bit_clr_s = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          bit_inc_s = 1'b1;
        end else begin
          bit_inc_s = 1'b0;
        end
      end
      ST_DONE: begin
        if (!RX_IN) begin
          edge_set1_s = 1'b1;
        end else begin
          edge_clr_s = 1'b1;
        end
      end
      default: edge_clr_s = 1'b0;
    endcase
  end

  // Frame FSM with registered strobes, busy and data_valid.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= ST_IDLE;
      p_r          <= PRESCALE_W'(MIN_PRESCALE);
      par_en_r     <= 1'b0;
      par_bad_r    <= 1'b0;
      strt_chk_r   <= 1'b0;
      deser_r      <= 1'b0;
      par_chk_r    <= 1'b0;
      stp_chk_r    <= 1'b0;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      strt_chk_r   <= 1'b0;
      deser_r      <= 1'b0;
      par_chk_r    <= 1'b0;
      stp_chk_r    <= 1'b0;
      data_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!RX_IN) begin
            state_r   <= ST_START;
            busy_r    <= 1'b1;
            p_r       <= p_nxt_s;
            par_en_r  <= PAR_EN;
            par_bad_r <= 1'b0;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_START: begin
          if (at_sample_s) strt_chk_r <= 1'b1;
          if (bit_done_s) begin
            if (strt_glitch) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (at_sample_s) deser_r <= 1'b1;
          if (bit_done_s && last_bit_s) begin
            state_r <= par_en_r ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (at_sample_s) par_chk_r <= 1'b1;
          if (bit_done_s) begin
            par_bad_r <= par_err;
            state_r   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (at_sample_s) stp_chk_r <= 1'b1;
          if (bit_done_s) begin
            state_r      <= ST_DONE;
            data_valid_r <= !stp_err && !(par_bad_r && par_en_r);
          end
        end
        ST_DONE: begin
          par_bad_r <= 1'b0;
          if (!RX_IN) begin
            state_r  <= ST_START;
            p_r      <= p_nxt_s;
            par_en_r <= PAR_EN;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign strt_chk_en = strt_chk_r;
  assign deser_en    = deser_r;
  assign par_chk_en  = par_chk_r;
  assign stp_chk_en  = stp_chk_r;
  assign data_valid  = data_valid_r;
  assign busy        = busy_r;
  assign dat_samp_en = busy_r;

`ifdef UART_RX_ERR_CNT_EN
  logic       err_evt_s;
  logic [7:0] err_cnt_r;

  // A frame error is a start-glitch abort or a DONE cycle without data_valid.
  always_comb begin
    err_evt_s = 1'b0;
    if (state_r == ST_START) begin
      err_evt_s = bit_done_s && strt_glitch;
    end else if (state_r == ST_DONE) begin
      err_evt_s = !data_valid_r;
    end else begin
      err_evt_s = 1'b0;
    end
  end

  // Saturating frame error counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_r <= 8'd0;
    end else if (err_evt_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign frame_err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected strobe/valid events
// (kind, cycle, edge_cnt); a negedge monitor pops and compares on each DUT pulse.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid, busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] frame_err_cnt;
`endif

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PRESCALE    (PRESCALE),
    .PAR_EN      (PAR_EN),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
`ifdef UART_RX_ERR_CNT_EN
    .frame_err_cnt (frame_err_cnt),
`endif
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Event kinds: 0 strt_chk, 1 deser, 2 par_chk, 3 stp_chk, 4 data_valid
  typedef struct {
    int kind;
    int cyc;
    int ecnt;
  } exp_t;
  exp_t q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input int kind);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cycle=%0d edge_cnt=%0d", kind, cyc, edge_cnt);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.ecnt != int'(edge_cnt)) begin
        errors++;
        $display("FAIL event actual kind=%0d cyc=%0d edge=%0d expected kind=%0d cyc=%0d edge=%0d",
                 kind, cyc, edge_cnt, e.kind, e.cyc, e.ecnt);
      end
    end
  endtask

  // Monitor: every asserted strobe/valid consumes one scoreboard entry.
  always @(negedge CLK) begin
    if (strt_chk_en) pop_cmp(0);
    if (deser_en)    pop_cmp(1);
    if (par_chk_en)  pop_cmp(2);
    if (stp_chk_en)  pop_cmp(3);
    if (data_valid)  pop_cmp(4);
  end

  task automatic add(input int kind, input int c, input int e, input int lim);
    exp_t x;
    x.kind = kind; x.cyc = c; x.ecnt = e;
    if (c < lim) q.push_back(x);
  endtask

  // Expected timeline of a frame whose edge_cnt==0 cycle is t0, effective ratio p.
  task automatic push_frame(input int t0, input int p, input logic pe, input logic good, input int lim);
    int s, n;
    s = p / 2 + 2;
    n = pe ? 11 : 10;
    add(0, t0 + s, s, lim);
    for (int i = 0; i < 8; i++) add(1, t0 + (1 + i) * p + s, s, lim);
    if (pe) add(2, t0 + 9 * p + s, s, lim);
    add(3, t0 + (n - 1) * p + s, s, lim);
    if (good) add(4, t0 + n * p, 0, lim);
  endtask

  // Drive line and checker flags for frame cycles j0..j_last (cycle j = t0+j).
  task automatic run_frame(input int p, input logic pe, input logic [7:0] d, input logic pbad,
                           input logic sbad, input logic next_low, input logic noise,
                           input int chg_ps, input int j0, input int j_last);
    int b, n;
    n = pe ? 11 : 10;
    for (int j = j0; j <= j_last; j++) begin
      @(negedge CLK);
      b = j / p;
      if (j == n * p)          RX_IN = next_low ? 1'b0 : 1'b1;
      else if (b == 0)         RX_IN = 1'b0;
      else if (b <= 8)         RX_IN = d[b-1];
      else if (b == 9 && pe)   RX_IN = ^d;
      else                     RX_IN = 1'b1;
      strt_glitch = (b == 0 || j == n * p) ? 1'b0 : noise;
      par_err     = (pe && b == 9) ? pbad : ((j == n * p) ? 1'b0 : noise);
      stp_err     = (b == n - 1) ? sbad : ((j == n * p) ? 1'b0 : noise);
      if (chg_ps != 0 && j == 20) PRESCALE = 6'(chg_ps);
    end
  endtask

  task automatic begin_frame(output int t0);
    @(negedge CLK);
    RX_IN = 1'b0;
    @(posedge CLK);
    #1;
    t0 = cyc;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  int t0;

  initial begin
    RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", int'({edge_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                               deser_en, data_valid, busy}), 0);
    RST = 1'b1;
    idle(3);

    // P=8, no parity, clean 0x55
    begin_frame(t0);
    push_frame(t0, 8, 1'b0, 1'b1, 1000000);
    run_frame(8, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 80);
    idle(4);
    chk("t1_busy_idle", int'(busy), 0);
    chk("t1_samp_idle", int'(dat_samp_en), 0);
`ifdef UART_RX_ERR_CNT_EN
    chk("t1_err_cnt", int'(frame_err_cnt), 0);
`endif

    // P=16 with parity, parity error
    PRESCALE = 6'd16; PAR_EN = 1'b1;
    begin_frame(t0);
    push_frame(t0, 16, 1'b1, 1'b0, 1000000);
    run_frame(16, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 176);
    idle(4);
`ifdef UART_RX_ERR_CNT_EN
    chk("t2_err_cnt", int'(frame_err_cnt), 1);
`endif

    // Start glitch abort, P=8
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    begin_frame(t0);
    push_frame(t0, 8, 1'b0, 1'b0, t0 + 8);
    @(negedge CLK);
    RX_IN = 1'b1; strt_glitch = 1'b1;
    repeat (7) @(negedge CLK);
    chk("t3_busy_before_abort", int'(busy), 1);
    @(negedge CLK);
    chk("t3_busy_after_abort", int'(busy), 0);
    chk("t3_edge_after_abort", int'(edge_cnt), 0);
    idle(12);
`ifdef UART_RX_ERR_CNT_EN
    chk("t3_err_cnt", int'(frame_err_cnt), 2);
`endif

    // Back-to-back frames, second start seen in DONE
    begin_frame(t0);
    push_frame(t0, 8, 1'b0, 1'b1, 1000000);
    push_frame(t0 + 80, 8, 1'b0, 1'b1, 1000000);
    run_frame(8, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 80);
    run_frame(8, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 80);
    idle(4);
    chk("t4_busy_idle", int'(busy), 0);

    // PRESCALE=4 clamps to 8; error flags toggled outside their windows
    PRESCALE = 6'd4;
    begin_frame(t0);
    push_frame(t0, 8, 1'b0, 1'b1, 1000000);
    run_frame(8, 1'b0, 8'hC4, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 80);
    idle(4);

    // PRESCALE=9 acts as 8; change to 32 mid-frame ignored
    PRESCALE = 6'd9;
    begin_frame(t0);
    push_frame(t0, 8, 1'b0, 1'b1, 1000000);
    run_frame(8, 1'b0, 8'h3B, 1'b0, 1'b0, 1'b0, 1'b0, 32, 0, 80);
    idle(4);
    chk("t5_prescale_now_32", int'(PRESCALE), 32);

    // Next frame picks up P=32, with parity, good
    PAR_EN = 1'b1;
    begin_frame(t0);
    push_frame(t0, 32, 1'b1, 1'b1, 1000000);
    run_frame(32, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 352);
    idle(4);
`ifdef UART_RX_ERR_CNT_EN
    chk("t5_err_cnt", int'(frame_err_cnt), 2);
`endif

    // Reset asserted in DATA at bit 3, then a fresh frame
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    begin_frame(t0);
    push_frame(t0, 8, 1'b0, 1'b1, t0 + 36);
    run_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 35);
    #2;
    RST = 1'b0;
    #1;
    chk("t6_reset_outputs", int'({edge_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
                                  deser_en, data_valid, busy}), 0);
`ifdef UART_RX_ERR_CNT_EN
    chk("t6_err_cnt_reset", int'(frame_err_cnt), 0);
`endif
    idle(2);
    RST = 1'b1;
    idle(3);
    begin_frame(t0);
    push_frame(t0, 8, 1'b0, 1'b1, 1000000);
    run_frame(8, 1'b0, 8'hE7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 80);
    idle(6);
    chk("t6_busy_idle", int'(busy), 0);

    chk("events_left_in_scoreboard", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
